// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX boundary buffer feeding the ALU.
// Two-entry queue (head drives the ALU, skid catches one extra op), operand
// bypass from EX/MEM and MEM/WB at capture, writeback snooping for held
// entries, load-use hazard back-pressure and synchronous flush.

`ifndef REGISTER_WIDTH
`define REGISTER_WIDTH 32
`endif

module alu_issue_stage #(
    parameter int WIDTH    = `REGISTER_WIDTH,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    // decode side
    input  logic                dec_valid,
    output logic                dec_ready,
    input  logic [WIDTH-1:0]    dec_a,
    input  logic [WIDTH-1:0]    dec_b,
    input  logic [REG_BITS-1:0] dec_rs,
    input  logic [REG_BITS-1:0] dec_rt,
    input  logic [WIDTH-1:0]    dec_imm,
    input  logic                dec_use_imm,
    input  logic [2:0]          dec_ctrl,
    input  logic [REG_BITS-1:0] dec_rd,
    input  logic                dec_reg_write,
    // EX/MEM producer
    input  logic                exm_we,
    input  logic [REG_BITS-1:0] exm_rd,
    input  logic [WIDTH-1:0]    exm_data,
    input  logic                exm_is_load,
    // MEM/WB writeback
    input  logic                wb_we,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic [WIDTH-1:0]    wb_data,
    // ALU side
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [2:0]          alu_ctrl,
    output logic [REG_BITS-1:0] ex_rd,
    output logic                ex_reg_write
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Source indices are kept with the operands so a held entry can keep
    // picking up writebacks until it issues.
    typedef struct packed {
        logic [WIDTH-1:0]    a;
        logic [WIDTH-1:0]    b;
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        logic                use_imm;
        logic [2:0]          ctrl;
        logic [REG_BITS-1:0] rd;
        logic                reg_write;
    } entry_t;

    state_t state;
    state_t state_next;
    entry_t head;
    entry_t skid;
    entry_t head_snoop;
    entry_t skid_snoop;
    entry_t new_entry;
    logic   hazard;
    logic   push;
    logic   pop;

    // Operand value at capture: register 0 reads zero, then the youngest
    // in-flight producer wins. A load in EX/MEM has no data yet and is
    // never forwarded (the hazard term stalls instead).
    function automatic logic [WIDTH-1:0] bypass(
        input logic [REG_BITS-1:0] idx,
        input logic [WIDTH-1:0]    reg_val,
        input logic                e_we,
        input logic                e_load,
        input logic [REG_BITS-1:0] e_rd,
        input logic [WIDTH-1:0]    e_data,
        input logic                w_we,
        input logic [REG_BITS-1:0] w_rd,
        input logic [WIDTH-1:0]    w_data
    );
        if (idx == '0)
            return '0;
        else if (e_we && !e_load && e_rd == idx)
            return e_data;
        else if (w_we && w_rd == idx)
            return w_data;
        else
            return reg_val;
    endfunction

    // A held entry whose source register is being written back takes the
    // new value; an immediate b operand is never overwritten.
    function automatic entry_t snoop(
        input entry_t              e,
        input logic                w_we,
        input logic [REG_BITS-1:0] w_rd,
        input logic [WIDTH-1:0]    w_data
    );
        entry_t r;
        r = e;
        if (w_we && w_rd != '0) begin
            if (e.rs == w_rd)
                r.a = w_data;
            if (!e.use_imm && e.rt == w_rd)
                r.b = w_data;
        end
        return r;
    endfunction

    // Hazard detect, capture bypass and writeback snoop of both held entries.
    always_comb begin
        hazard = dec_valid && exm_we && exm_is_load && (exm_rd != '0) &&
                 ((exm_rd == dec_rs) || (!dec_use_imm && exm_rd == dec_rt));

        new_entry.a         = bypass(dec_rs, dec_a, exm_we, exm_is_load, exm_rd,
                                     exm_data, wb_we, wb_rd, wb_data);
        new_entry.b         = dec_use_imm ? dec_imm :
                              bypass(dec_rt, dec_b, exm_we, exm_is_load, exm_rd,
                                     exm_data, wb_we, wb_rd, wb_data);
        new_entry.rs        = dec_rs;
        new_entry.rt        = dec_rt;
        new_entry.use_imm   = dec_use_imm;
        new_entry.ctrl      = dec_ctrl;
        new_entry.rd        = dec_rd;
        new_entry.reg_write = dec_reg_write;

        head_snoop = snoop(head, wb_we, wb_rd, wb_data);
        skid_snoop = snoop(skid, wb_we, wb_rd, wb_data);
    end

    // Occupancy state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_next;
    end

    // Next occupancy: flush overrides any transfer in the same cycle.
    // NOTE: default assignment first so no path through the case leaves
    // state_next unassigned and infers a latch.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (push) state_next = ONE;
                ONE: begin
                    if (push && !pop)
                        state_next = TWO;
                    else if (pop && !push)
                        state_next = EMPTY;
                end
                TWO:   if (pop) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Handshake outputs: registered occupancy combined with the live hazard.
    always_comb begin
        ex_valid  = (state != EMPTY);
        dec_ready = (state != TWO) && !hazard;
        push      = dec_valid && dec_ready;
        pop       = ex_valid && ex_ready;
    end

    // Entry storage: held entries snoop every cycle, then moves/loads apply.
    // NOTE: the two entries are reset explicitly because the head drives the
    // ALU outputs directly and those must read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            skid <= '0;
        end else begin
            head <= head_snoop;
            skid <= skid_snoop;
            if (!flush) begin
                unique case (state)
                    EMPTY: if (push) head <= new_entry;
                    ONE: begin
                        if (push && pop)
                            head <= new_entry;
                        else if (push)
                            skid <= new_entry;
                    end
                    TWO:   if (pop) head <= skid_snoop;
                    default: ;
                endcase
            end
        end
    end

    assign alu_a        = head.a;
    assign alu_b        = head.b;
    assign alu_ctrl     = head.ctrl;
    assign ex_rd        = head.rd;
    assign ex_reg_write = head.reg_write;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.

module tb_alu_issue_stage;

    localparam int W = 32;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         dec_valid;
    logic         dec_ready;
    logic [W-1:0] dec_a, dec_b, dec_imm;
    logic [R-1:0] dec_rs, dec_rt, dec_rd;
    logic         dec_use_imm;
    logic [2:0]   dec_ctrl;
    logic         dec_reg_write;
    logic         exm_we, exm_is_load;
    logic [R-1:0] exm_rd;
    logic [W-1:0] exm_data;
    logic         wb_we;
    logic [R-1:0] wb_rd;
    logic [W-1:0] wb_data;
    logic         ex_valid, ex_ready;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_ctrl;
    logic [R-1:0] ex_rd;
    logic         ex_reg_write;

    int vectors     = 0;
    int miscompares = 0;

    alu_issue_stage #(.WIDTH(W), .REG_BITS(R)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_a(dec_a), .dec_b(dec_b), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_ctrl(dec_ctrl),
        .dec_rd(dec_rd), .dec_reg_write(dec_reg_write),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data), .exm_is_load(exm_is_load),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    // Reference model: an in-order list of ops waiting for / sitting at the ALU.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [R-1:0] rs;
        logic [R-1:0] rt;
        logic         use_imm;
        logic [2:0]   ctrl;
        logic [R-1:0] rd;
        logic         rw;
    } op_t;

    op_t model_q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value a source register should hold given what is in flight right now.
    function automatic logic [W-1:0] src_value(input logic [R-1:0] idx, input logic [W-1:0] rf);
        if (idx == 0) return '0;
        if (exm_we && !exm_is_load && exm_rd == idx) return exm_data;
        if (wb_we && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    // One clock cycle: check outputs against the model, then advance the model.
    // Called at the falling edge with inputs already applied.
    task automatic step();
        logic   hz, exp_ready, push, pop, s_flush, s_wb_we;
        logic [R-1:0] s_wb_rd;
        logic [W-1:0] s_wb_data;
        op_t    e;
        #1;
        if (reset) begin
            model_q.delete();
            chk("rst_ex_valid", ex_valid, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_alu_ctrl", alu_ctrl, 0);
            chk("rst_ex_rd", ex_rd, 0);
            chk("rst_ex_reg_write", ex_reg_write, 0);
            @(posedge clk);
            @(negedge clk);
            return;
        end
        hz = dec_valid && exm_we && exm_is_load && exm_rd != 0 &&
             (exm_rd == dec_rs || (!dec_use_imm && exm_rd == dec_rt));
        exp_ready = (model_q.size() < 2) && !hz;
        chk("dec_ready", dec_ready, exp_ready);
        chk("ex_valid", ex_valid, model_q.size() > 0);
        if (model_q.size() > 0) begin
            chk("alu_a", alu_a, model_q[0].a);
            chk("alu_b", alu_b, model_q[0].b);
            chk("alu_ctrl", alu_ctrl, model_q[0].ctrl);
            chk("ex_rd", ex_rd, model_q[0].rd);
            chk("ex_reg_write", ex_reg_write, model_q[0].rw);
        end
        push = dec_valid && exp_ready;
        pop  = (model_q.size() > 0) && ex_ready;
        e.a       = src_value(dec_rs, dec_a);
        e.b       = dec_use_imm ? dec_imm : src_value(dec_rt, dec_b);
        e.rs      = dec_rs;
        e.rt      = dec_rt;
        e.use_imm = dec_use_imm;
        e.ctrl    = dec_ctrl;
        e.rd      = dec_rd;
        e.rw      = dec_reg_write;
        s_flush = flush; s_wb_we = wb_we; s_wb_rd = wb_rd; s_wb_data = wb_data;
        @(posedge clk);
        if (s_flush) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (s_wb_we && s_wb_rd != 0) begin
                foreach (model_q[i]) begin
                    if (model_q[i].rs == s_wb_rd) model_q[i].a = s_wb_data;
                    if (!model_q[i].use_imm && model_q[i].rt == s_wb_rd) model_q[i].b = s_wb_data;
                end
            end
            if (push) model_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [R-1:0] rs, input logic [R-1:0] rt,
                          input logic [2:0] ctrl, input logic [R-1:0] rd);
        dec_valid = 1'b1; dec_a = a; dec_b = b; dec_rs = rs; dec_rt = rt;
        dec_ctrl = ctrl; dec_rd = rd; dec_reg_write = 1'b1;
        dec_use_imm = 1'b0; dec_imm = '0;
    endtask

    task automatic idle_side();
        dec_valid = 1'b0; exm_we = 1'b0; exm_is_load = 1'b0; wb_we = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        dec_a = '0; dec_b = '0; dec_imm = '0; dec_rs = '0; dec_rt = '0; dec_rd = '0;
        dec_use_imm = 1'b0; dec_ctrl = '0; dec_reg_write = 1'b0; dec_valid = 1'b0;
        exm_we = 1'b0; exm_rd = '0; exm_data = '0; exm_is_load = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        @(negedge clk);

        // 1: reset held with an op offered, then release
        set_op(32'h11, 32'h12, 5'd1, 5'd2, 3'b000, 5'd3);
        step(); step();
        reset = 1'b0;
        step();
        chk("t1_ex_valid", ex_valid, 1);
        idle_side();
        step();

        // 2: EX/MEM bypass beats MEM/WB on the same register
        set_op(32'd5, 32'd7, 5'd3, 5'd6, 3'b010, 5'd8);
        exm_we = 1'b1; exm_rd = 5'd3; exm_data = 32'h10;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h20;
        step();
        idle_side();
        chk("t2_alu_a", alu_a, 32'h10);
        chk("t2_alu_b", alu_b, 32'd7);
        chk("t2_alu_ctrl", alu_ctrl, 3'b010);
        step();

        // 3: load-use stall, then accept with writeback data
        set_op(32'd1, 32'd2, 5'd4, 5'd9, 3'b001, 5'd10);
        exm_we = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd4; exm_data = 32'hDEAD;
        step();
        chk("t3_stall", dec_ready, 0);
        step();
        exm_we = 1'b0; exm_is_load = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        step();
        idle_side();
        chk("t3_alu_a", alu_a, 32'h44);
        step();

        // 4: fill both entries, third op refused, snoop held op's rt
        ex_ready = 1'b0;
        set_op(32'hA1, 32'hA2, 5'd1, 5'd2, 3'b011, 5'd10); step();
        set_op(32'hB1, 32'hB2, 5'd5, 5'd12, 3'b100, 5'd11); step();
        set_op(32'hC1, 32'hC2, 5'd6, 5'd7, 3'b101, 5'd13); step();
        chk("t4_full", dec_ready, 0);
        dec_valid = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd12; wb_data = 32'h55;
        step();
        wb_we = 1'b0; ex_ready = 1'b1;
        chk("t4_first_rd", ex_rd, 5'd10);
        step();
        chk("t4_second_rd", ex_rd, 5'd11);
        chk("t4_snoop_b", alu_b, 32'h55);
        step();

        // 5: TWO with in+out promotes skid without accepting, then flush
        ex_ready = 1'b0;
        set_op(32'hD1, 32'hD2, 5'd1, 5'd2, 3'b000, 5'd14); step();
        set_op(32'hE1, 32'hE2, 5'd1, 5'd2, 3'b001, 5'd15); step();
        ex_ready = 1'b1;
        set_op(32'hF1, 32'hF2, 5'd1, 5'd2, 3'b110, 5'd16); step();
        chk("t5_promoted_rd", ex_rd, 5'd15);
        chk("t5_still_valid", ex_valid, 1);
        flush = 1'b1;
        step();
        idle_side();
        chk("t5_flushed", ex_valid, 0);
        step();

        // 6: register 0 ignores a bypass; immediate ignores a writeback
        set_op(32'h99, 32'h98, 5'd0, 5'd7, 3'b010, 5'd17);
        dec_use_imm = 1'b1; dec_imm = 32'd2;
        exm_we = 1'b1; exm_rd = 5'd0; exm_data = 32'hFF;
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        step();
        idle_side();
        chk("t6_alu_a", alu_a, 32'd0);
        chk("t6_alu_b", alu_b, 32'd2);
        step();

        // reset in the middle of a full buffer
        ex_ready = 1'b0;
        set_op(32'h1, 32'h2, 5'd1, 5'd2, 3'b000, 5'd18); step();
        set_op(32'h3, 32'h4, 5'd3, 5'd4, 3'b000, 5'd19); step();
        idle_side();
        reset = 1'b1; step();
        reset = 1'b0; ex_ready = 1'b1; step();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            dec_valid     = ($urandom_range(99) < 70);
            dec_a         = $urandom; dec_b = $urandom; dec_imm = $urandom;
            dec_rs        = 5'($urandom_range(7));
            dec_rt        = 5'($urandom_range(7));
            dec_rd        = 5'($urandom_range(7));
            dec_use_imm   = ($urandom_range(99) < 25);
            dec_ctrl      = 3'($urandom_range(6));
            dec_reg_write = 1'($urandom_range(1));
            exm_we        = ($urandom_range(99) < 50);
            exm_is_load   = ($urandom_range(99) < 25);
            exm_rd        = 5'($urandom_range(7));
            exm_data      = $urandom;
            wb_we         = ($urandom_range(99) < 50);
            wb_rd         = 5'($urandom_range(7));
            wb_data       = $urandom;
            ex_ready      = ($urandom_range(99) < 60);
            flush         = ($urandom_range(99) < 3);
            reset         = ($urandom_range(199) == 0);
            step();
        end
        reset = 1'b0;
        idle_side();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
